alu_cmd_driver: RTL and testbench

//   Initiator side of the ALU operand/opcode interface. Accepts tagged operation

---
 rtl/alu_cmd_driver_if.sv | 62 ++++++
 rtl/alu_cmd_driver.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver_if
// Bundles the three handshakes around the ALU command driver:
//   - command channel (cmd_*): tagged operations from the stimulus source
//   - ALU channel     (alu_*): operands/opcode to the ALU, result back
//   - response channel(rsp_*): captured result plus tag to the consumer
//
// Modports
//   master : the driver itself (accepts commands, drives the ALU, returns
//            responses)
//   slave  : the surrounding environment (command source, ALU, consumer)
//
// Parameters
//   DATA_W : ALU operand width
//   OUT_W  : ALU result width
//   TAG_W  : command tag width
// ---------------------------------------------------------------------------
interface alu_cmd_driver_if #(
    parameter int DATA_W = 1,
    parameter int OUT_W  = 2,
    parameter int TAG_W  = 4
);

    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [1:0]        cmd_op;
    logic [TAG_W-1:0]  cmd_tag;

    // ALU channel
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_op;
    logic [OUT_W-1:0]  alu_out;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
// Initiator side of the ALU operand/opcode interface. Tagged commands are
// accepted over valid/ready into a small FIFO; one operation at a time is
// issued to the ALU, the ALU inputs are held for the ALU pipeline latency,
// the result is captured verbatim and returned together with the tag.
//
// Ports
//   clk   : clock
//   rst   : asynchronous, active-high reset (flushes FIFO, drops any
//           in-flight operation)
//   bus   : alu_cmd_driver_if.master (cmd_*, alu_*, rsp_* channels)
//   busy  : FSM not IDLE or FIFO not empty
//
// Optional feature (macro ALU_DRV_CHECK_EN)
//   When defined, a reference model recomputes the expected result from the
//   held ALU inputs and two extra ports appear:
//     rsp_mismatch : 1 when the captured result differs from the model,
//                    valid together with rsp_valid
//     err_cnt      : 16-bit saturating count of mismatching responses,
//                    bumped on the response handshake
//   When undefined, the port list is clk, rst, bus, busy only.
//
// Parameters
//   DATA_W, OUT_W, TAG_W : channel widths (must match the interface)
//   FIFO_DEPTH           : command FIFO entries, power of 2, >= 2
//   ALU_LAT              : clock edges from alu_* change to alu_out valid, >= 1
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int DATA_W     = 1,
    parameter int OUT_W      = 2,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_cmd_driver_if.master        bus,
    output logic                    busy
`ifdef ALU_DRV_CHECK_EN
    ,
    output logic                    rsp_mismatch,
    output logic [15:0]             err_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(ALU_LAT + 1);
    localparam int ENTRY_W = 2 * DATA_W + 2 + TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;

    logic [DATA_W-1:0]  ent_a;
    logic [DATA_W-1:0]  ent_b;
    logic [1:0]         ent_op;
    logic [TAG_W-1:0]   ent_tag;

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  alu_a_q;
    logic [DATA_W-1:0]  alu_b_q;
    logic [1:0]         alu_op_q;
    logic [TAG_W-1:0]   cur_tag;
    logic               rsp_valid_q;
    logic [OUT_W-1:0]   rsp_data_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               capture;
    logic               handshake;

    // The extra pointer bit distinguishes full from empty when the index
    // bits coincide. cmd_ready is also forced low while reset is asserted
    // so every output reads 0 during reset.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign bus.cmd_ready = !full && !rst;

    // Push only when not full, so a pop in the same cycle never lets a
    // command slip past a full FIFO. Pop is owned by the IDLE state.
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop  = (state == IDLE) && !empty;

    assign {ent_a, ent_b, ent_op, ent_tag} = mem[rd_ptr[PTR_W-1:0]];

    // Storage has no reset: the pointers alone decide what is valid, so a
    // reset flushes the FIFO without clearing the array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
        end
    end

    // Read and write pointers wrap naturally modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // cnt holds the number of edges seen since the load edge; the result is
    // sampled on the edge where that count reaches ALU_LAT.
    assign capture   = ((state == DRIVE) || (state == WAIT)) && (cnt == CNT_W'(ALU_LAT));
    assign handshake = (state == RESP) && bus.rsp_ready;

    // Operation sequencer: load the ALU inputs from the FIFO head, hold them
    // for the ALU latency, capture the result and keep the response stable
    // until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            cur_tag     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        alu_a_q  <= ent_a;
                        alu_b_q  <= ent_b;
                        alu_op_q <= ent_op;
                        cur_tag  <= ent_tag;
                        cnt      <= CNT_W'(1);
                        state    <= DRIVE;
                    end
                end
                DRIVE, WAIT: begin
                    if (capture) begin
                        rsp_data_q  <= bus.alu_out;
                        rsp_tag_q   <= cur_tag;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (handshake) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;

    assign busy = (state != IDLE) || !empty;

`ifdef ALU_DRV_CHECK_EN
    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    localparam int CALC_W = 2 * DATA_W + OUT_W;

    logic [CALC_W-1:0] calc_a;
    logic [CALC_W-1:0] calc_b;
    logic [OUT_W-1:0]  expected;

    // Operands are widened before the arithmetic so products and borrows
    // are formed at full precision and then truncated, which makes SUB wrap
    // modulo 2^OUT_W. A zero on either DIV operand yields 0.
    always_comb begin
        calc_a   = CALC_W'(alu_a_q);
        calc_b   = CALC_W'(alu_b_q);
        expected = '0;
        case (alu_op_q)
            2'b00: expected = OUT_W'(calc_a + calc_b);
            2'b01: expected = OUT_W'(calc_a - calc_b);
            2'b10: expected = OUT_W'(calc_a * calc_b);
            2'b11: begin
                if ((calc_a == '0) || (calc_b == '0)) begin
                    expected = '0;
                end else begin
                    expected = OUT_W'(calc_a / calc_b);
                end
            end
            default: expected = '0;
        endcase
    end

    // The mismatch flag is set alongside the captured result and cleared on
    // the handshake; the error counter saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_mismatch <= 1'b0;
            err_cnt      <= '0;
        end else if (capture) begin
            rsp_mismatch <= (bus.alu_out != expected);
        end else if (handshake) begin
            rsp_mismatch <= 1'b0;
            if (rsp_mismatch && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
// Directed bench for alu_cmd_driver: reset state, single ADD timing,
// back-to-back ordering, response backpressure with a full FIFO, reset in
// the middle of an operation and, with ALU_DRV_CHECK_EN, the built-in
// mismatch checker. A one-register ALU model gives the two-edge latency.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

    localparam int DATA_W     = 1;
    localparam int OUT_W      = 2;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ALU_LAT    = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef ALU_DRV_CHECK_EN
    logic        rsp_mismatch;
    logic [15:0] err_cnt;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    alu_cmd_driver_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    alu_cmd_driver #(
        .DATA_W(DATA_W),
        .OUT_W(OUT_W),
        .TAG_W(TAG_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy)
`ifdef ALU_DRV_CHECK_EN
        ,
        .rsp_mismatch(rsp_mismatch),
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: one register stage, so a result is ready on the second edge
    // after the inputs change. force_zero corrupts the result on demand.
    logic [OUT_W-1:0] alu_res_q;
    logic             force_zero;

    always @(posedge clk) begin
        case (bus.alu_op)
            2'b00: alu_res_q <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            2'b01: alu_res_q <= {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            2'b10: alu_res_q <= {1'b0, bus.alu_a & bus.alu_b};
            default: alu_res_q <= (bus.alu_a && bus.alu_b) ? 2'd1 : 2'd0;
        endcase
    end

    assign bus.alu_out = force_zero ? '0 : alu_res_q;

    // Response recorder: every handshake is stored with the ALU inputs seen
    // on that edge, which must still be the ones of that command.
    typedef struct {
        logic [OUT_W-1:0]  data;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        op;
    } rsp_t;

    rsp_t rsp_q[$];

    always @(posedge clk) begin
        rsp_t r;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            r.data = bus.rsp_data;
            r.tag  = bus.rsp_tag;
            r.a    = bus.alu_a;
            r.b    = bus.alu_b;
            r.op   = bus.alu_op;
            rsp_q.push_back(r);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    endtask

    // Presents one command starting at a negedge and returns on the negedge
    // after it has been accepted, with cmd_valid dropped.
    task automatic applyStimulus(input logic a, input logic b, input logic [1:0] op,
                                 input logic [3:0] tag);
        int n;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_tag   = tag;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checkOutput("push_timeout", 32'(bus.cmd_ready), 32'd1);
        end else begin
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input int count, input string name);
        int n;
        n = 0;
        while (rsp_q.size() < count && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(rsp_q.size()), 32'(count));
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b1;
        force_zero    = 1'b0;
        rst           = 1'b0;

        // reset asserted: every output low
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_busy",      32'(busy),          32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_alu_a",     32'(bus.alu_a),     32'd0);

        // release and idle
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("idle_busy",      32'(busy),          32'd0);
        checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("idle_alu_a",     32'(bus.alu_a),     32'd0);
        checkOutput("idle_alu_b",     32'(bus.alu_b),     32'd0);
        checkOutput("idle_alu_op",    32'(bus.alu_op),    32'd0);
        checkOutput("idle_rsp_data",  32'(bus.rsp_data),  32'd0);
        checkOutput("idle_rsp_tag",   32'(bus.rsp_tag),   32'd0);

        // single ADD 1+1 tag 3: loaded on E0, held 2 edges, response after E0+2
        applyStimulus(1'b1, 1'b1, 2'b00, 4'd3);
        @(negedge clk);
        checkOutput("add_e0_alu_a",   32'(bus.alu_a),     32'd1);
        checkOutput("add_e0_alu_b",   32'(bus.alu_b),     32'd1);
        checkOutput("add_e0_alu_op",  32'(bus.alu_op),    32'd0);
        checkOutput("add_e0_valid",   32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("add_e1_alu_a",   32'(bus.alu_a),     32'd1);
        checkOutput("add_e1_valid",   32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("add_rsp_valid",  32'(bus.rsp_valid), 32'd1);
        checkOutput("add_rsp_data",   32'(bus.rsp_data),  32'd2);
        checkOutput("add_rsp_tag",    32'(bus.rsp_tag),   32'd3);
        @(negedge clk);
        checkOutput("add_done_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("add_done_busy",  32'(busy),          32'd0);

        // back-to-back SUB 0-1, MULT 1*1, DIV 1/0
        rsp_q.delete();
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd1);
        applyStimulus(1'b1, 1'b1, 2'b10, 4'd2);
        applyStimulus(1'b1, 1'b0, 2'b11, 4'd3);
        waitRsp(3, "b2b_count");
        if (rsp_q.size() >= 3) begin
            checkOutput("b2b0_data", 32'(rsp_q[0].data), 32'd3);
            checkOutput("b2b0_tag",  32'(rsp_q[0].tag),  32'd1);
            checkOutput("b2b0_alu",  32'({rsp_q[0].a, rsp_q[0].b, rsp_q[0].op}), 32'b0101);
            checkOutput("b2b1_data", 32'(rsp_q[1].data), 32'd1);
            checkOutput("b2b1_tag",  32'(rsp_q[1].tag),  32'd2);
            checkOutput("b2b1_alu",  32'({rsp_q[1].a, rsp_q[1].b, rsp_q[1].op}), 32'b1110);
            checkOutput("b2b2_data", 32'(rsp_q[2].data), 32'd0);
            checkOutput("b2b2_tag",  32'(rsp_q[2].tag),  32'd3);
            checkOutput("b2b2_alu",  32'({rsp_q[2].a, rsp_q[2].b, rsp_q[2].op}), 32'b1011);
        end
        waitIdle("b2b_idle");

        // backpressure: 1 in flight + 4 queued, then the FIFO is full
        rsp_q.delete();
        bus.rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 4'd4);
        applyStimulus(1'b1, 1'b1, 2'b01, 4'd5);
        applyStimulus(1'b1, 1'b0, 2'b10, 4'd6);
        applyStimulus(1'b1, 1'b1, 2'b11, 4'd7);
        applyStimulus(1'b0, 1'b1, 2'b01, 4'd8);
        checkOutput("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("bp_busy",       32'(busy),          32'd1);
        bus.cmd_a     = 1'b1;
        bus.cmd_b     = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_tag   = 4'd9;
        bus.cmd_valid = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("bp_still_full", 32'(bus.cmd_ready), 32'd0);
        checkOutput("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("bp_hold_data",  32'(bus.rsp_data),  32'd1);
        checkOutput("bp_hold_tag",   32'(bus.rsp_tag),   32'd4);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        waitRsp(5, "bp_count");
        if (rsp_q.size() >= 5) begin
            checkOutput("bp0", 32'({rsp_q[0].tag, rsp_q[0].data}), {26'd0, 4'd4, 2'd1});
            checkOutput("bp1", 32'({rsp_q[1].tag, rsp_q[1].data}), {26'd0, 4'd5, 2'd0});
            checkOutput("bp2", 32'({rsp_q[2].tag, rsp_q[2].data}), {26'd0, 4'd6, 2'd0});
            checkOutput("bp3", 32'({rsp_q[3].tag, rsp_q[3].data}), {26'd0, 4'd7, 2'd1});
            checkOutput("bp4", 32'({rsp_q[4].tag, rsp_q[4].data}), {26'd0, 4'd8, 2'd3});
        end
        waitIdle("bp_idle");
`ifdef ALU_DRV_CHECK_EN
        checkOutput("chk_no_errors", 32'(err_cnt), 32'd0);
`endif

        // reset while the first of three commands sits in WAIT
        rsp_q.delete();
        applyStimulus(1'b1, 1'b1, 2'b01, 4'd10);
        applyStimulus(1'b1, 1'b1, 2'b00, 4'd11);
        applyStimulus(1'b1, 1'b1, 2'b00, 4'd12);
        checkOutput("mid_alu_op_pre", 32'(bus.alu_op), 32'd1);
        checkOutput("mid_busy_pre",   32'(busy),       32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_alu_a",  32'(bus.alu_a),     32'd0);
        checkOutput("mid_rst_alu_b",  32'(bus.alu_b),     32'd0);
        checkOutput("mid_rst_alu_op", 32'(bus.alu_op),    32'd0);
        checkOutput("mid_rst_busy",   32'(busy),          32'd0);
        checkOutput("mid_rst_valid",  32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_ready",  32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("mid_no_rsp",     32'(rsp_q.size()),  32'd0);
        checkOutput("mid_post_busy",  32'(busy),          32'd0);
        checkOutput("mid_post_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_post_ready", 32'(bus.cmd_ready), 32'd1);

`ifdef ALU_DRV_CHECK_EN
        // corrupted ALU result on ADD 1+1 must be flagged and counted once
        begin
            int n;
            force_zero = 1'b1;
            applyStimulus(1'b1, 1'b1, 2'b00, 4'd13);
            n = 0;
            while (!bus.rsp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            checkOutput("chk_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("chk_mismatch",  32'(rsp_mismatch),  32'd1);
            checkOutput("chk_rsp_data",  32'(bus.rsp_data),  32'd0);
            @(negedge clk);
            checkOutput("chk_err_cnt",   32'(err_cnt),       32'd1);
            force_zero = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
